cla_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the team's single-cycle 4-bit CLA.
- Operands are split into GROUP-bit lookahead groups. Each pipeline stage resolves one group, and the carry travels between stages in registers.
- Valid/ready handshake on input and output, with backpressure.
- Used as the wide-add datapath element in ALU and accumulator blocks.

---
 rtl/cla_pkg.sv | 32 +++
 rtl/cla_group.sv | 59 +++++
 rtl/cla_pipe_adder.sv | 118 +++++++++++
 tb/tb_cla_pipe_adder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_pkg
// Purpose  : Shared constants, NSTAGE helper and pipeline stage record for
//            the pipelined carry-lookahead adder. Macro: CLA_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
package cla_pkg;

   localparam int CLA_GROUP_DEFAULT = 4;
   localparam int CLA_GROUP_MIN     = 1;
   localparam int CLA_GROUP_MAX     = 8;
   localparam int CLA_MAX_WIDTH     = 64;

   function automatic int cla_nstage(input int width, input int group);
      return width / group;
   endfunction

   // Bits above the configured WIDTH stay zero and are trimmed by synthesis.
   typedef struct packed {
      logic                     valid;
      logic                     carry;
`ifdef CLA_OVF_EN
      logic                     ovf;
`endif
      logic [CLA_MAX_WIDTH-1:0] sum;
      logic [CLA_MAX_WIDTH-1:0] a;
      logic [CLA_MAX_WIDTH-1:0] b;
   } stage_t;

endpackage
`default_nettype wire

// File: rtl/cla_group.sv
`default_nettype none
// ============================================================================
// Module   : cla_group
// Purpose  : GROUP-bit combinational carry-lookahead slice. Macro: CLA_OVF_EN
//            adds the carry-into-MSB output used for signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
module cla_group #(
   parameter int GROUP = 4
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             cin,
   output logic [GROUP-1:0] sum,
`ifdef CLA_OVF_EN
   output logic             cmsb,
`endif
   output logic             cout
);

   logic [GROUP-1:0] gen;
   logic [GROUP-1:0] prop;
   logic [GROUP:0]   carry;
   logic             term;
   logic             acc;

   assign gen  = a & b;
   assign prop = a ^ b;

   // Every carry is a flat sum of products of g, p and cin; no ripple chain.
   always_comb begin
      carry    = '0;
      term     = 1'b0;
      acc      = 1'b0;
      carry[0] = cin;
      for (int i = 0; i < GROUP; i++) begin
         acc = cin;
         for (int j = 0; j <= i; j++) begin
            acc = acc & prop[j];
         end
         for (int j = 0; j <= i; j++) begin
            term = gen[j];
            for (int k = j + 1; k <= i; k++) begin
               term = term & prop[k];
            end
            acc = acc | term;
         end
         carry[i+1] = acc;
      end
   end

   assign sum  = prop ^ carry[GROUP-1:0];
   assign cout = carry[GROUP];
`ifdef CLA_OVF_EN
   assign cmsb = carry[GROUP-1];
`endif

endmodule
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_pipe_adder
// Purpose  : Pipelined carry-lookahead adder/subtractor, one GROUP-bit group
//            per stage, valid/ready on both sides. Macro: CLA_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int GROUP = CLA_GROUP_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
`ifdef CLA_OVF_EN
   output logic             out_ovf,
`endif
   output logic             out_cout
);

   localparam int NSTAGE = cla_nstage(WIDTH, GROUP);

   if ((GROUP < CLA_GROUP_MIN) || (GROUP > CLA_GROUP_MAX)) begin : g_bad_group
      $error("cla_pipe_adder: GROUP out of range");
   end
   if ((WIDTH % GROUP) != 0) begin : g_bad_width
      $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
   end
   if (WIDTH > CLA_MAX_WIDTH) begin : g_too_wide
      $error("cla_pipe_adder: WIDTH exceeds CLA_MAX_WIDTH");
   end

   // stg[0] holds the accepted beat; stg[k+1] holds it after group k resolved.
   stage_t stg [0:NSTAGE];
   stage_t entry;
   logic   advance;

   assign advance  = !stg[NSTAGE].valid || out_ready;
   assign in_ready = advance;

   always_comb begin
      entry               = '0;
      entry.valid         = in_valid;
      entry.carry         = in_sub | in_cin;
      entry.a[WIDTH-1:0]  = in_a;
      entry.b[WIDTH-1:0]  = in_b ^ {WIDTH{in_sub}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stg[0] <= '0;
      end else if (advance) begin
         stg[0] <= entry;
      end
   end

   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      stage_t           cur;
      stage_t           nxt;
      logic [GROUP-1:0] gsum;
      logic             gcout;
`ifdef CLA_OVF_EN
      logic             gcmsb;
`endif

      assign cur = stg[k];

      cla_group #(
         .GROUP (GROUP)
      ) u_group (
         .a    (cur.a[k*GROUP +: GROUP]),
         .b    (cur.b[k*GROUP +: GROUP]),
         .cin  (cur.carry),
         .sum  (gsum),
`ifdef CLA_OVF_EN
         .cmsb (gcmsb),
`endif
         .cout (gcout)
      );

      // Overflow is refreshed every stage; only the top group's value survives.
      always_comb begin
         nxt                       = cur;
         nxt.sum[k*GROUP +: GROUP] = gsum;
         nxt.carry                 = gcout;
`ifdef CLA_OVF_EN
         nxt.ovf                   = gcmsb ^ gcout;
`endif
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            stg[k+1] <= '0;
         end else if (advance) begin
            stg[k+1] <= nxt;
         end
      end
   end

   assign out_valid = stg[NSTAGE].valid;
   assign out_sum   = stg[NSTAGE].sum[WIDTH-1:0];
   assign out_cout  = stg[NSTAGE].carry;
`ifdef CLA_OVF_EN
   assign out_ovf   = stg[NSTAGE].ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_pipe_adder
// Purpose  : Directed and short random scoreboard bench for cla_pipe_adder
//            (WIDTH=16, GROUP=4). Macro: CLA_OVF_EN enables overflow checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;

   localparam int WIDTH = 16;
   localparam int GROUP = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
`ifdef CLA_OVF_EN
   logic             out_ovf;
`endif

   always #5 clk = ~clk;

   cla_pipe_adder #(
      .WIDTH (WIDTH),
      .GROUP (GROUP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
`ifdef CLA_OVF_EN
      .out_ovf   (out_ovf),
`endif
      .out_cout  (out_cout)
   );

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   pops   = 0;

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic cin, input logic sub);
      exp_t             e;
      logic [WIDTH-1:0] be;
      logic [WIDTH:0]   r;
      be     = sub ? ~b : b;
      r      = {1'b0, a} + {1'b0, be} + {{WIDTH{1'b0}}, (sub ? 1'b1 : cin)};
      e.sum  = r[WIDTH-1:0];
      e.cout = r[WIDTH];
      e.ovf  = (a[WIDTH-1] == be[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Sampled at the falling edge: handshakes seen here transfer on the next rise.
   task automatic monitor();
      exp_t e;
      if (rst) begin
         sb.delete();
         return;
      end
      if (out_valid && out_ready) begin
         chk("out_expected", (sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            pops++;
            chk("sum", out_sum, e.sum);
            chk("cout", out_cout, e.cout);
`ifdef CLA_OVF_EN
            chk("ovf", out_ovf, e.ovf);
`endif
         end
      end
      if (in_valid && in_ready) begin
         sb.push_back(model(in_a, in_b, in_cin, in_sub));
      end
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic cin, input logic sub);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_sub   = sub;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      in_cin   = 1'b0;
      in_sub   = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 40) begin
         step();
         n++;
      end
      chk("drain_empty", sb.size(), 0);
   endtask

   task automatic wait_latency(input string tag);
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk(tag, n, 4);
   endtask

   initial begin
      int         cnt;
      int         p0;
      logic [WIDTH-1:0] held;

      rst       = 1'b1;
      out_ready = 1'b1;
      idle();
      step();
      step();
      rst = 1'b0;

      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_cout", out_cout, 0);
      chk("rst_in_ready", in_ready, 1);
`ifdef CLA_OVF_EN
      chk("rst_out_ovf", out_ovf, 0);
`endif

      drive_beat(16'h0001, 16'h0002, 1'b0, 1'b0);
      step();
      idle();
      wait_latency("single_latency");
      chk("single_sum", out_sum, 16'h0003);
      chk("single_cout", out_cout, 0);
      drain();

      drive_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      step();
      drive_beat(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      step();
      idle();
      drain();

      for (int j = 0; j < 12; j++) begin
         if (j < 8) begin
            drive_beat(WIDTH'(j), WIDTH'(16'h0100 * j), 1'b0, 1'b0);
            chk("stream_in_ready", in_ready, 1);
         end else begin
            idle();
         end
         step();
         chk("stream_out_valid", out_valid, (j >= 4));
      end
      idle();
      drain();

      p0        = pops;
      out_ready = 1'b0;
      cnt       = 0;
      while (in_ready && cnt < 10) begin
         drive_beat(WIDTH'(16'h1111 * (cnt + 1)), 16'h0F0F, cnt[0], 1'b0);
         step();
         cnt++;
      end
      idle();
      chk("bp_accepted", cnt, 5);
      held = out_sum;
      for (int j = 0; j < 5; j++) begin
         step();
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_sum_stable", out_sum, held);
      end
      out_ready = 1'b1;
      drain();
      chk("bp_pop_count", pops - p0, 5);

      drive_beat(16'h0005, 16'h0007, 1'b0, 1'b1);
      step();
      drive_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      step();
      drive_beat(16'h8000, 16'h0001, 1'b1, 1'b1);
      step();
      idle();
      drain();

      for (int j = 0; j < 24; j++) begin
         drive_beat(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
         in_valid  = 1'($urandom_range(0, 3) != 0);
         out_ready = 1'($urandom_range(0, 2) != 0);
         step();
      end
      idle();
      out_ready = 1'b1;
      drain();

      for (int j = 0; j < 3; j++) begin
         drive_beat(WIDTH'(16'h0101 * (j + 3)), 16'h2222, 1'b1, 1'b0);
         step();
      end
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("flush_out_valid", out_valid, 0);
      for (int j = 0; j < 3; j++) begin
         step();
         chk("flush_out_valid", out_valid, 0);
      end
      drive_beat(16'h1234, 16'h4321, 1'b1, 1'b0);
      step();
      idle();
      wait_latency("post_rst_latency");
      chk("post_rst_sum", out_sum, 16'h5556);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
